key_sequence_sender: RTL and testbench
======================================

Name: key_sequence_sender

Overview:
- Transmitter side of the serial key-code lock interface.
- On request, shifts a latched N-bit code onto a single `key` line, one bit per clock, MSB first.
- Then waits a bounded time for the lock's unlock indication. Retries a bounded number of times before reporting failure.
- Sits between control logic (`start`/`done`/`fail`) and a serial sequence-detecting lock.

Parameters:
- CODE_LEN, 3, number of code bits sent per attempt (>=1).
- TIMEOUT, 4, WAIT cycles allowed for `lock_in` before the attempt fails (>=1).
- MAX_RETRY, 2, additional attempts after the first failed attempt (>=0).
- GAP_LEN, 2, cycles `key` is held 0 between attempts so the lock returns to idle (>=1).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset; state cleared while 0.
- start  input  1  request; sampled only in IDLE.
- code  input  CODE_LEN  code to send; latched on accepted start.
- lock_in  input  1  unlock indication from the lock; level, sampled in WAIT only.
- key  output  1  serial key bit; registered.
- busy  output  1  high from accepted start until return to IDLE.
- done  output  1  one-cycle pulse: unlock seen.
- fail  output  1  one-cycle pulse: all attempts exhausted.

Interface decision: one clock `clk`; reset is asynchronous and active-low on port `reset`.

Behaviour:
- Reset (`reset`=0, any state, including mid-transfer): state=IDLE, `key`=0, `busy`=0, `done`=0, `fail`=0, all counters 0. Release is synchronous to next edge.
- All outputs are registered.
- IDLE: `key`=0, `busy`=0.
  - `start`=1 at edge T0: latch `code`, `bit_cnt`=0, `retry_cnt`=0, go SEND.
  - At T0: `key`<=code[CODE_LEN-1], `busy`<=1.
- SEND:
  - Edge T0+i drives bit code[CODE_LEN-1-i]; each bit is held exactly one cycle.
  - At edge T0+CODE_LEN: `key`<=0, `tmo_cnt`=0, go WAIT.
  - `lock_in` is ignored in SEND.
- WAIT: `key`=0.
  - `lock_in`=1 sampled: `done`<=1 for one cycle, `busy`<=0, go IDLE.
  - Otherwise `tmo_cnt` increments. After TIMEOUT edges without `lock_in`:
    - if `retry_cnt`<MAX_RETRY: `retry_cnt`++, go GAP;
    - else `fail`<=1 for one cycle, `busy`<=0, go IDLE.
- GAP: `key`=0 for GAP_LEN cycles, then re-enter SEND with `bit_cnt`=0 using the latched code. SEND, WAIT and GAP timing are otherwise identical to the first attempt.
- `start` while `busy`=1 is ignored and not queued.
- `start` high in the same cycle `done`/`fail` pulses: ignored. A new start is accepted only in IDLE, earliest the next edge.
- `code` changes after acceptance have no effect.
- `done` and `fail` are mutually exclusive.
- Total attempts = MAX_RETRY+1.
- Counter widths: $clog2 of respective max value + 1. No wrap is possible in legal operation.

Optional Feature:
- Macro KEY_SENDER_ABORT_EN.
- Defined: adds input `abort` (1 bit).
  - `abort`=1 at any edge in SEND/WAIT/GAP: go IDLE, `key`<=0, `busy`<=0, no `done`/`fail` pulse.
  - `abort` has priority over `lock_in`/timeout in the same cycle. Ignored in IDLE.
- Undefined: port absent; behaviour as above.

Decomposition:
- Package key_lock_pkg:
  - state enum (IDLE, SEND, WAIT, GAP);
  - default CODE_LEN/TIMEOUT/MAX_RETRY/GAP_LEN constants;
  - shared code width constant, also used by the lock side.
- One natural sub-module: key_shift_out. It is a loadable MSB-first shift register with `bit_cnt` and a `last_bit` flag. The FSM, timeout and retry logic stay in the top.

Test Plan:
- code=3'b101, start pulse, behavioural lock model (detects 1,0,1, asserts one cycle) on `lock_in` -> `key` = 1,0,1 on cycles T0+1..T0+3; `done` pulse within TIMEOUT; `busy` high throughout; `fail` never.
- code=3'b110, lock never unlocks, MAX_RETRY=2 -> three SEND bursts 1,1,0 separated by 2 cycles of `key`=0; single `fail` pulse after third timeout; `busy` drops same edge.
- Wrong code first then correct: lock model forced high on second attempt -> `done` after attempt 2, `retry_cnt`=1, no `fail`.
- `start` reasserted mid-SEND with different code -> ignored; transmitted bits match original latched code.
- `reset` driven low mid-SEND (after bit 2) -> `key`, `busy`, `done`, `fail` = 0 immediately (asynchronous); after release, `start` with code=3'b101 sends cleanly from MSB.
- With KEY_SENDER_ABORT_EN: `abort` during WAIT coincident with `lock_in`=1 -> IDLE next edge, no `done`; without macro, bench compiles with no `abort` port.

Source files
------------

// File: rtl/key_lock_pkg.sv
// Shared types and defaults for the serial key-code lock interface (sender and lock side).
package key_lock_pkg;

  typedef enum logic [1:0] {IDLE, SEND, WAIT, GAP} state_t;

  localparam int unsigned DEF_CODE_LEN  = 3;
  localparam int unsigned DEF_TIMEOUT   = 4;
  localparam int unsigned DEF_MAX_RETRY = 2;
  localparam int unsigned DEF_GAP_LEN   = 2;

  localparam int unsigned CODE_W = DEF_CODE_LEN;

endpackage

// File: rtl/key_shift_out.sv
// Loadable MSB-first shift register feeding the serial key line, with bit counter and last-bit flag.
module key_shift_out
  import key_lock_pkg::*;
#(
  parameter int unsigned CODE_LEN = CODE_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                shift,
  input  logic [CODE_LEN-1:0] data,
  output logic                head,
  output logic                last_bit
);

  localparam int unsigned BIT_W = $clog2(CODE_LEN) + 1;

  logic [CODE_LEN-1:0] shreg;
  logic [BIT_W-1:0]    bit_cnt;

  // The MSB is driven onto key by the caller at load time, so only the remaining bits are kept
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      shreg   <= data << 1;
      bit_cnt <= '0;
    end else if (shift) begin
      shreg   <= shreg << 1;
      bit_cnt <= bit_cnt + BIT_W'(1);
    end
  end

  assign head     = shreg[CODE_LEN-1];
  assign last_bit = (bit_cnt == BIT_W'(CODE_LEN - 1));

endmodule

// File: rtl/key_sequence_sender.sv
// Serial key-code transmitter with bounded unlock wait and retries.
// Optional abort input enabled by defining KEY_SENDER_ABORT_EN.
module key_sequence_sender
  import key_lock_pkg::*;
#(
  parameter int unsigned CODE_LEN  = CODE_W,
  parameter int unsigned TIMEOUT   = DEF_TIMEOUT,
  parameter int unsigned MAX_RETRY = DEF_MAX_RETRY,
  parameter int unsigned GAP_LEN   = DEF_GAP_LEN
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CODE_LEN-1:0] code,
  input  logic                lock_in,
`ifdef KEY_SENDER_ABORT_EN
  input  logic                abort,
`endif
  output logic                key,
  output logic                busy,
  output logic                done,
  output logic                fail
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT) + 1;
  localparam int unsigned RTY_W = $clog2(MAX_RETRY + 1) + 1;
  localparam int unsigned GAP_W = $clog2(GAP_LEN) + 1;

  state_t              state;
  logic [CODE_LEN-1:0] code_q;
  logic [TMO_W-1:0]    tmo_cnt;
  logic [RTY_W-1:0]    retry_cnt;
  logic [GAP_W-1:0]    gap_cnt;

  logic                gap_last;
  logic                load;
  logic                shift;
  logic                head;
  logic                last_bit;
  logic                abort_hit;
  logic [CODE_LEN-1:0] load_data;

`ifdef KEY_SENDER_ABORT_EN
  assign abort_hit = abort && (state != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  assign gap_last  = (gap_cnt == GAP_W'(GAP_LEN - 1));
  assign load      = ((state == IDLE) && start) || ((state == GAP) && gap_last);
  assign shift     = (state == SEND) && !last_bit;
  assign load_data = (state == IDLE) ? code : code_q;

  key_shift_out #(
    .CODE_LEN (CODE_LEN)
  ) u_shift (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .shift    (shift),
    .data     (load_data),
    .head     (head),
    .last_bit (last_bit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      code_q    <= '0;
      tmo_cnt   <= '0;
      retry_cnt <= '0;
      gap_cnt   <= '0;
      key       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
    end else begin
      done <= 1'b0;
      fail <= 1'b0;
      if (abort_hit) begin
        state <= IDLE;
        key   <= 1'b0;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              code_q    <= code;
              retry_cnt <= '0;
              key       <= code[CODE_LEN-1];
              busy      <= 1'b1;
              state     <= SEND;
            end
          end
          SEND: begin
            if (last_bit) begin
              key     <= 1'b0;
              tmo_cnt <= '0;
              state   <= WAIT;
            end else begin
              key <= head;
            end
          end
          WAIT: begin
            if (lock_in) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
              if (retry_cnt < RTY_W'(MAX_RETRY)) begin
                retry_cnt <= retry_cnt + RTY_W'(1);
                gap_cnt   <= '0;
                state     <= GAP;
              end else begin
                fail  <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
              end
            end else begin
              tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
          end
          GAP: begin
            // Last gap cycle restarts the burst exactly like an accepted start
            if (gap_last) begin
              key   <= code_q[CODE_LEN-1];
              state <= SEND;
            end else begin
              gap_cnt <= gap_cnt + GAP_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_key_sequence_sender.sv
// Directed bench for key_sequence_sender: vector table plus hand-written corner sequences.
module tb_key_sequence_sender;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] code;
  logic       lock_in;
  logic       key;
  logic       busy;
  logic       done;
  logic       fail;
`ifdef KEY_SENDER_ABORT_EN
  logic       abort;
`endif

  logic       lock_sel;
  logic       lock_force;
  logic [2:0] hist;

  int total;
  int bad;

  typedef struct {
    logic       start;
    logic [2:0] code;
    logic       key;
    logic       busy;
    logic       done;
    logic       fail;
  } vec_t;

  vec_t vecs[$];

  key_sequence_sender #(
    .CODE_LEN  (3),
    .TIMEOUT   (4),
    .MAX_RETRY (2),
    .GAP_LEN   (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .code    (code),
    .lock_in (lock_in),
`ifdef KEY_SENDER_ABORT_EN
    .abort   (abort),
`endif
    .key     (key),
    .busy    (busy),
    .done    (done),
    .fail    (fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural lock: unlocks for one cycle after the last three key bits were 1,0,1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) hist <= '0;
    else        hist <= {hist[1:0], key};
  end
  assign lock_in = lock_sel ? (hist == 3'b101) : lock_force;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic k, input logic b,
                           input logic d, input logic f);
    check({tag, "_key"},  {31'd0, key},  {31'd0, k});
    check({tag, "_busy"}, {31'd0, busy}, {31'd0, b});
    check({tag, "_done"}, {31'd0, done}, {31'd0, d});
    check({tag, "_fail"}, {31'd0, fail}, {31'd0, f});
  endtask

  function automatic void add(input logic s, input logic [2:0] c, input logic k,
                              input logic b, input logic d, input logic f);
    vec_t v;
    v.start = s; v.code = c; v.key = k; v.busy = b; v.done = d; v.fail = f;
    vecs.push_back(v);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    start = 1'b0;
    code  = 3'b000;
    lock_sel   = 1'b0;
    lock_force = 1'b0;
`ifdef KEY_SENDER_ABORT_EN
    abort = 1'b0;
`endif

    // code 101 with the lock model: bits 1,0,1 then done on the first WAIT edge
    add(1'b1, 3'b101, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 3'b101, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 3'b101, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 3'b101, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 3'b101, 1'b0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0);
    // code 110, never unlocks: attempt period 3 send + 4 wait + 2 gap = 9 edges, fail on edge 25
    for (int k = 0; k < 27; k++)
      add(k == 0, 3'b110, (k % 9) < 2, k < 25, 1'b0, k == 25);

    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    check_out("idle", 1'b0, 1'b0, 1'b0, 1'b0);

    lock_sel = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].start;
      code  = vecs[i].code;
      tick();
      check_out($sformatf("vec%0d", i), vecs[i].key, vecs[i].busy, vecs[i].done, vecs[i].fail);
    end
    start = 1'b0;
    tick();

    // Second attempt unlocks; lock_in held high through that SEND must be ignored
    lock_sel   = 1'b0;
    lock_force = 1'b0;
    start = 1'b1;
    code  = 3'b100;
    tick();
    start = 1'b0;
    repeat (9) tick();
    check_out("retry_burst", 1'b1, 1'b1, 1'b0, 1'b0);
    lock_force = 1'b1;
    repeat (3) tick();
    check_out("retry_send_ignores_lock", 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check_out("retry_done", 1'b0, 1'b0, 1'b1, 1'b0);
    check("retry_cnt", {29'd0, dut.retry_cnt}, 32'd1);
    lock_force = 1'b0;
    tick();
    check_out("retry_after", 1'b0, 1'b0, 1'b0, 1'b0);

    // start with a new code mid-SEND is ignored; start during WAIT is ignored too
    start = 1'b1;
    code  = 3'b101;
    tick();
    check_out("restart_b2", 1'b1, 1'b1, 1'b0, 1'b0);
    code = 3'b010;
    tick();
    check_out("restart_b1", 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check_out("restart_b0", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    check_out("restart_wait", 1'b0, 1'b1, 1'b0, 1'b0);
    lock_force = 1'b1;
    tick();
    check_out("restart_done", 1'b0, 1'b0, 1'b1, 1'b0);
    start = 1'b0;
    lock_force = 1'b0;
    tick();
    check_out("restart_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-SEND, then a clean transfer
    start = 1'b1;
    code  = 3'b110;
    tick();
    start = 1'b0;
    tick();
    check_out("pre_reset", 1'b1, 1'b1, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_out("async_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    lock_sel = 1'b1;
    start = 1'b1;
    code  = 3'b101;
    tick();
    check_out("post_reset_b2", 1'b1, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    tick();
    check_out("post_reset_b1", 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check_out("post_reset_b0", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    check_out("post_reset_wait", 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check_out("post_reset_done", 1'b0, 1'b0, 1'b1, 1'b0);
    tick();

`ifdef KEY_SENDER_ABORT_EN
    // abort wins over a coincident lock_in in WAIT
    lock_sel   = 1'b0;
    lock_force = 1'b0;
    start = 1'b1;
    code  = 3'b111;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check_out("abort_wait", 1'b0, 1'b1, 1'b0, 1'b0);
    abort = 1'b1;
    lock_force = 1'b1;
    tick();
    check_out("abort_hit", 1'b0, 1'b0, 1'b0, 1'b0);
    abort = 1'b0;
    lock_force = 1'b0;
    tick();
    check_out("abort_idle", 1'b0, 1'b0, 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
